// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: MMIO word map, line count
// and the line index that carries the timer flag when IRQ_TIMER_EN is defined.
package irq_pkg;

  localparam int N_LINES    = 8;
  localparam int TIMER_LINE = 7;
  localparam int ADDR_W     = 3;
  localparam int DATA_W     = 64;

  typedef enum logic [ADDR_W-1:0] {
    IRQ_PENDING = 3'd0,
    IRQ_MASK    = 3'd1,
    IRQ_MODE    = 3'd2,
    IRQ_COUNT   = 3'd3,
    IRQ_COMPARE = 3'd4,
    IRQ_CTRL    = 3'd5
  } irq_addr_e;

endpackage

// File: rtl/irq_sync.sv
// Per-line two-flop synchronizer (s1, s2) plus a history flop (s3) used for
// rising-edge detection of asynchronous interrupt lines.
module irq_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] hist
);

  logic [WIDTH-1:0] s1, s2, s3;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign sync = s2;
  assign hist = s3;

endmodule

// File: rtl/irq_ctrl.sv
// MMIO interrupt controller: per-line edge/level capture, W1C pending, mask.
// Optional free-running compare timer on line 7 when IRQ_TIMER_EN is defined.
module irq_ctrl #(
  parameter int                          N_LINES    = irq_pkg::N_LINES,
  parameter logic [irq_pkg::N_LINES-1:0] MASK_RESET = {irq_pkg::N_LINES{1'b1}}
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_LINES-1:0]          irq_in,
  input  logic [irq_pkg::ADDR_W-1:0]  addr,
  input  logic                        wr_en,
  input  logic [irq_pkg::DATA_W-1:0]  wr_data,
  output logic [irq_pkg::DATA_W-1:0]  rd_data,
  output logic [N_LINES-1:0]          interrupt_source
);
  import irq_pkg::*;

  logic [N_LINES-1:0] pending, pending_next;
  logic [N_LINES-1:0] mask, mode;
  logic [N_LINES-1:0] sync, hist, rise, clr;

  irq_sync #(.WIDTH(N_LINES)) u_sync (
    .clock (clock),
    .reset (reset),
    .raw   (irq_in),
    .sync  (sync),
    .hist  (hist)
  );

  assign rise = sync & ~hist;
  assign clr  = (wr_en && addr == IRQ_PENDING) ? wr_data[N_LINES-1:0] : '0;

`ifdef IRQ_TIMER_EN
  logic [31:0] count, count_next, compare;
  logic        timer_en, timer_match, compare_wr;

  always_comb begin
    count_next = count;
    if (wr_en && addr == IRQ_COUNT)
      count_next = wr_data[31:0];
    else if (timer_en)
      count_next = count + 32'd1;
  end

  assign timer_match = timer_en && (count_next == compare);
  assign compare_wr  = wr_en && addr == IRQ_COMPARE;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count    <= '0;
      compare  <= 32'hFFFF_FFFF;
      timer_en <= 1'b0;
    end else begin
      count <= count_next;
      if (compare_wr)
        compare <= wr_data[31:0];
      if (wr_en && addr == IRQ_CTRL)
        timer_en <= wr_data[0];
    end
  end

  logic unused_wr_data;
  assign unused_wr_data = ^wr_data[DATA_W-1:32];
`else
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data[DATA_W-1:N_LINES];
`endif

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pending_next = pending;
    for (int i = 0; i < N_LINES; i++) begin
      if (mode[i])
        pending_next[i] = rise[i] | (pending[i] & ~clr[i]);
      else
        pending_next[i] = sync[i];
    end
`ifdef IRQ_TIMER_EN
    // Line 7 carries the timer flag: the raw line and W1C are ignored here.
    if (compare_wr)
      pending_next[TIMER_LINE] = 1'b0;
    else if (timer_match)
      pending_next[TIMER_LINE] = 1'b1;
    else
      pending_next[TIMER_LINE] = pending[TIMER_LINE];
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
      mask    <= MASK_RESET;
      mode    <= '0;
    end else begin
      pending <= pending_next;
      if (wr_en && addr == IRQ_MASK)
        mask <= wr_data[N_LINES-1:0];
      if (wr_en && addr == IRQ_MODE)
        mode <= wr_data[N_LINES-1:0];
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      IRQ_PENDING: rd_data[N_LINES-1:0] = pending;
      IRQ_MASK:    rd_data[N_LINES-1:0] = mask;
      IRQ_MODE:    rd_data[N_LINES-1:0] = mode;
`ifdef IRQ_TIMER_EN
      IRQ_COUNT:   rd_data[31:0]        = count;
      IRQ_COMPARE: rd_data[31:0]        = compare;
      IRQ_CTRL:    rd_data[0]           = timer_en;
`endif
      default:     rd_data              = '0;
    endcase
  end

  assign interrupt_source = pending & mask;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expectations are queued as stimulus is driven
// and popped when the DUT output is sampled. Covers both IRQ_TIMER_EN builds.
module tb_irq_ctrl;
  import irq_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  irq_in = '0;
  logic [2:0]  addr = '0;
  logic        wr_en = 1'b0;
  logic [63:0] wr_data = '0;
  logic [63:0] rd_data;
  logic [7:0]  interrupt_source;

`ifdef IRQ_TIMER_EN
  localparam logic [7:0] LINE_MASK = 8'h7F;
`else
  localparam logic [7:0] LINE_MASK = 8'hFF;
`endif

  typedef struct {
    string       name;
    logic [63:0] value;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  irq_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .irq_in           (irq_in),
    .addr             (addr),
    .wr_en            (wr_en),
    .wr_data          (wr_data),
    .rd_data          (rd_data),
    .interrupt_source (interrupt_source)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input string name, input logic [63:0] value);
    exp_t e;
    e.name  = name;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic mmio_write(input logic [2:0] a, input logic [63:0] d);
    addr    = a;
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
    wr_data = '0;
  endtask

  task automatic mmio_read(input logic [2:0] a, output logic [63:0] d);
    addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic test_reset();
    exp_t        e;
    logic [63:0] rd;
    logic [2:0]  a_list [8];
    logic [63:0] v_list [8];
    a_list = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`ifdef IRQ_TIMER_EN
    v_list = '{64'h0, 64'hFF, 64'h0, 64'h0, 64'hFFFF_FFFF, 64'h0, 64'h0, 64'h0};
`else
    v_list = '{64'h0, 64'hFF, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
`endif
    irq_in = 8'hFF;
    tick();
    tick();
    push_exp("reset irq_src held", 64'h0);
    e = sb.pop_front(); n_checks++;
    if ({56'h0, interrupt_source} !== e.value) begin
      n_fail++; $display("FAIL %s: got %h want %h", e.name, interrupt_source, e.value);
    end
    irq_in = 8'h00;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) push_exp($sformatf("reset rd addr%0d", i), v_list[i]);
    for (int i = 0; i < 8; i++) begin
      mmio_read(a_list[i], rd);
      e = sb.pop_front(); n_checks++;
      if (rd !== e.value) begin
        n_fail++; $display("FAIL %s: got %h want %h", e.name, rd, e.value);
      end
    end
    tick();
  endtask

  task automatic test_edge();
    exp_t e;
    mmio_write(IRQ_MODE, 64'h01);
    addr = IRQ_PENDING;
    for (int i = 0; i <= 12; i++) begin
      irq_in  = (i == 0) ? 8'h01 : 8'h00;
      wr_en   = (i == 10);
      wr_data = (i == 10) ? 64'h1 : 64'h0;
      push_exp($sformatf("edge pending e%0d", i), (i >= 2 && i < 10) ? 64'h1 : 64'h0);
      push_exp($sformatf("edge irq_src e%0d", i), (i >= 2 && i < 10) ? 64'h1 : 64'h0);
      tick();
      e = sb.pop_front(); n_checks++;
      if (rd_data !== e.value) begin
        n_fail++; $display("FAIL %s: got %h want %h", e.name, rd_data, e.value);
      end
      e = sb.pop_front(); n_checks++;
      if ({56'h0, interrupt_source} !== e.value) begin
        n_fail++; $display("FAIL %s: got %h want %h", e.name, interrupt_source, e.value);
      end
    end
    wr_en = 1'b0;
    wr_data = '0;
  endtask

  task automatic test_level();
    exp_t e;
    mmio_write(IRQ_MODE, 64'h00);
    addr = IRQ_PENDING;
    for (int i = 0; i <= 8; i++) begin
      irq_in  = (i <= 4) ? 8'h08 : 8'h00;
      wr_en   = (i == 3);
      wr_data = (i == 3) ? 64'h08 : 64'h0;
      push_exp($sformatf("level irq_src e%0d", i), (i >= 2 && i <= 6) ? 64'h08 : 64'h0);
      tick();
      e = sb.pop_front(); n_checks++;
      if ({56'h0, interrupt_source} !== e.value) begin
        n_fail++; $display("FAIL %s: got %h want %h", e.name, interrupt_source, e.value);
      end
    end
    wr_en = 1'b0;
    wr_data = '0;
  endtask

  task automatic test_mask();
    exp_t        e;
    logic [63:0] rd;
    mmio_write(IRQ_MODE, 64'h04);
    mmio_write(IRQ_MASK, 64'hFB);
    for (int i = 0; i < 4; i++) begin
      irq_in = (i == 0) ? 8'h04 : 8'h00;
      tick();
    end
    push_exp("mask pending", 64'h04);
    push_exp("mask irq_src masked", 64'h00);
    mmio_read(IRQ_PENDING, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.value) begin
      n_fail++; $display("FAIL %s: got %h want %h", e.name, rd, e.value);
    end
    e = sb.pop_front(); n_checks++;
    if ({56'h0, interrupt_source} !== e.value) begin
      n_fail++; $display("FAIL %s: got %h want %h", e.name, interrupt_source, e.value);
    end
    addr = IRQ_MASK; wr_data = 64'hFF; wr_en = 1'b1;
    push_exp("mask irq_src before write edge", 64'h00);
    push_exp("mask irq_src after write", 64'h04);
    #1;
    e = sb.pop_front(); n_checks++;
    if ({56'h0, interrupt_source} !== e.value) begin
      n_fail++; $display("FAIL %s: got %h want %h", e.name, interrupt_source, e.value);
    end
    tick();
    wr_en = 1'b0;
    e = sb.pop_front(); n_checks++;
    if ({56'h0, interrupt_source} !== e.value) begin
      n_fail++; $display("FAIL %s: got %h want %h", e.name, interrupt_source, e.value);
    end
    mmio_write(IRQ_PENDING, 64'h04);
  endtask

  task automatic test_collision();
    exp_t e;
    mmio_write(IRQ_MODE, 64'h01);
    addr = IRQ_PENDING;
    for (int i = 0; i <= 4; i++) begin
      irq_in  = (i == 0) ? 8'h01 : 8'h00;
      wr_en   = (i == 2 || i == 4);
      wr_data = (i == 2 || i == 4) ? 64'h1 : 64'h0;
      push_exp($sformatf("collision pending e%0d", i), (i == 2 || i == 3) ? 64'h1 : 64'h0);
      tick();
      e = sb.pop_front(); n_checks++;
      if (rd_data !== e.value) begin
        n_fail++; $display("FAIL %s: got %h want %h", e.name, rd_data, e.value);
      end
    end
    wr_en = 1'b0;
    wr_data = '0;
  endtask

  task automatic test_mode_change();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      irq_in = (i == 0) ? 8'h01 : 8'h00;
      tick();
    end
    push_exp("mode change keeps pending", 64'h1);
    push_exp("mode change level reload", 64'h0);
    mmio_write(IRQ_MODE, 64'h00);
    addr = IRQ_PENDING;
    #1;
    e = sb.pop_front(); n_checks++;
    if (rd_data !== e.value) begin
      n_fail++; $display("FAIL %s: got %h want %h", e.name, rd_data, e.value);
    end
    tick();
    e = sb.pop_front(); n_checks++;
    if (rd_data !== e.value) begin
      n_fail++; $display("FAIL %s: got %h want %h", e.name, rd_data, e.value);
    end
  endtask

`ifdef IRQ_TIMER_EN
  task automatic test_timer();
    exp_t        e;
    logic [63:0] rd;
    logic [63:0] cnt_exp [4];
    cnt_exp = '{64'hFFFF_FFFE, 64'hFFFF_FFFF, 64'h0, 64'h1};
    irq_in = 8'h80;
    mmio_write(IRQ_COUNT, 64'hFFFF_FFFE);
    mmio_write(IRQ_COMPARE, 64'h1);
    mmio_write(IRQ_CTRL, 64'h1);
    for (int j = 0; j < 4; j++) begin
      push_exp($sformatf("timer count c%0d", j), cnt_exp[j]);
      push_exp($sformatf("timer irq_src c%0d", j), (j == 3) ? 64'h80 : 64'h0);
      mmio_read(IRQ_COUNT, rd);
      e = sb.pop_front(); n_checks++;
      if (rd !== e.value) begin
        n_fail++; $display("FAIL %s: got %h want %h", e.name, rd, e.value);
      end
      e = sb.pop_front(); n_checks++;
      if ({56'h0, interrupt_source} !== e.value) begin
        n_fail++; $display("FAIL %s: got %h want %h", e.name, interrupt_source, e.value);
      end
      if (j < 3) tick();
    end
    push_exp("timer flag survives w1c", 64'h80);
    push_exp("timer flag cleared by compare", 64'h00);
    mmio_write(IRQ_PENDING, 64'h80);
    e = sb.pop_front(); n_checks++;
    if ({56'h0, interrupt_source} !== e.value) begin
      n_fail++; $display("FAIL %s: got %h want %h", e.name, interrupt_source, e.value);
    end
    mmio_write(IRQ_COMPARE, 64'h0);
    e = sb.pop_front(); n_checks++;
    if ({56'h0, interrupt_source} !== e.value) begin
      n_fail++; $display("FAIL %s: got %h want %h", e.name, interrupt_source, e.value);
    end
    mmio_write(IRQ_CTRL, 64'h0);
    irq_in = 8'h00;
  endtask
`else
  task automatic test_line7();
    exp_t        e;
    logic [63:0] rd;
    mmio_write(IRQ_MODE, 64'h80);
    for (int i = 0; i < 4; i++) begin
      irq_in = (i == 0) ? 8'h80 : 8'h00;
      tick();
    end
    push_exp("line7 irq_src", 64'h80);
    e = sb.pop_front(); n_checks++;
    if ({56'h0, interrupt_source} !== e.value) begin
      n_fail++; $display("FAIL %s: got %h want %h", e.name, interrupt_source, e.value);
    end
    for (int a = 3; a < 8; a++) mmio_write(3'(a), '1);
    for (int a = 3; a < 8; a++) push_exp($sformatf("unmapped rd addr%0d", a), 64'h0);
    push_exp("line7 pending after unmapped writes", 64'h80);
    for (int a = 3; a < 8; a++) begin
      mmio_read(3'(a), rd);
      e = sb.pop_front(); n_checks++;
      if (rd !== e.value) begin
        n_fail++; $display("FAIL %s: got %h want %h", e.name, rd, e.value);
      end
    end
    mmio_read(IRQ_PENDING, rd);
    e = sb.pop_front(); n_checks++;
    if (rd !== e.value) begin
      n_fail++; $display("FAIL %s: got %h want %h", e.name, rd, e.value);
    end
    mmio_write(IRQ_PENDING, 64'h80);
  endtask
`endif

  task automatic test_reset_mid();
    exp_t e;
    mmio_write(IRQ_MODE, 64'h0F);
    irq_in = 8'hFF;
    addr = IRQ_PENDING;
    for (int i = 0; i < 4; i++) tick();
    push_exp("pre-reset pending", {56'h0, LINE_MASK});
    e = sb.pop_front(); n_checks++;
    if (rd_data !== e.value) begin
      n_fail++; $display("FAIL %s: got %h want %h", e.name, rd_data, e.value);
    end
    reset = 1'b1;
    push_exp("async reset irq_src", 64'h0);
    push_exp("async reset pending", 64'h0);
    #1;
    e = sb.pop_front(); n_checks++;
    if ({56'h0, interrupt_source} !== e.value) begin
      n_fail++; $display("FAIL %s: got %h want %h", e.name, interrupt_source, e.value);
    end
    e = sb.pop_front(); n_checks++;
    if (rd_data !== e.value) begin
      n_fail++; $display("FAIL %s: got %h want %h", e.name, rd_data, e.value);
    end
    tick();
    tick();
    reset = 1'b0;
    addr = IRQ_MODE; wr_data = 64'h0F; wr_en = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      push_exp($sformatf("post-reset pending r%0d", r),
               (r == 3) ? {56'h0, LINE_MASK & 8'hF0} : 64'h0);
      tick();
      wr_en = 1'b0;
      wr_data = '0;
      addr = IRQ_PENDING;
      #1;
      e = sb.pop_front(); n_checks++;
      if (r < 3 && rd_data !== e.value) begin
        n_fail++; $display("FAIL %s: got %h want %h", e.name, rd_data, e.value);
      end else if (r == 3 && (rd_data & 64'hF0) !== e.value) begin
        n_fail++; $display("FAIL %s: got %h want %h", e.name, rd_data & 64'hF0, e.value);
      end
    end
    irq_in = 8'h00;
  endtask

  initial begin
    test_reset();
    test_edge();
    test_level();
    test_mask();
    test_collision();
    test_mode_change();
`ifdef IRQ_TIMER_EN
    test_timer();
`else
    test_line7();
`endif
    test_reset_mid();
    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard leftover: %0d entries, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end

endmodule
